// File: rtl/unidade_controle_if.sv
// Bus between the fetch/decode/control sequencer and the rest of the datapath
// (instruction memory, ALU, register bank).
//
// Timing contract: there is no valid/ready pair on this bus. The sequencer
// owns all timing. instrucao must be the combinational read of pc and is
// sampled only on the clock edge that leaves BUSCA. zero must be valid by the
// clock edge that leaves PROXIMO. Every other signal is driven by the
// sequencer. The strobes are valid throughout the state that estado reports.
interface unidade_controle_if;
  logic [31:0] instrucao;
  logic        zero;
  logic [31:0] pc;
  logic [3:0]  estado;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        regiwrite;
  logic        memtoreg;
  logic        memread;
  logic        memwrite;
  logic        alusrc;
  logic        branch;
  logic [1:0]  aluop;
  logic        parado;
  logic [31:0] instret;

  // Sequencer side
  modport master (
    input  instrucao, zero,
    output pc, estado, rs1, rs2, rd, imm, funct3, funct7b5,
           regiwrite, memtoreg, memread, memwrite, alusrc, branch,
           aluop, parado, instret
  );

  // Datapath / memory side
  modport slave (
    output instrucao, zero,
    input  pc, estado, rs1, rs2, rd, imm, funct3, funct7b5,
           regiwrite, memtoreg, memread, memwrite, alusrc, branch,
           aluop, parado, instret
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle fetch/decode/control sequencer for a small RV32I subset
// (R-type, OP-IMM, lw, sw, beq). It holds pc, IR and the retired-instruction
// counter. The state code on estado is shared with the register bank, which
// uses it to gate its own read/write cycles.
module unidade_controle (
  input  logic              clk,
  input  logic              reset,
  unidade_controle_if.master bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    BUSCA       = 4'b0000,
    DECODIFICA  = 4'b0001,
    EXECUCAO    = 4'b0010,
    ENDERECO    = 4'b0011,
    MEMORIA     = 4'b0100,
    ESCRITA_MEM = 4'b0101,
    DESVIO      = 4'b0110,
    PROXIMO     = 4'b0111,
    PARADA      = 4'b1111
  } estado_t;

  estado_t     estado_q;
  estado_t     estado_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic [31:0] imm_w;

  logic [6:0]  opcode;
  logic        is_r;
  logic        is_opimm;
  logic        is_lw;
  logic        is_sw;
  logic        is_beq;
  logic        beq_ok;
  logic        uses_imm;

  logic        regiwrite_w;
  logic        memtoreg_w;
  logic        memread_w;
  logic        memwrite_w;
  logic        alusrc_w;
  logic        branch_w;
  logic [1:0]  aluop_w;

  // Opcode classification from the instruction register
  assign opcode   = ir_q[6:0];
  assign is_r     = (opcode == OP_R);
  assign is_opimm = (opcode == OP_IMM);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  // Only funct3 000 of the branch opcode is implemented; the rest halt.
  assign beq_ok   = is_beq && (ir_q[14:12] == 3'b000);
  // Instructions whose ALU second operand is the immediate
  assign uses_imm = is_opimm || is_lw || is_sw;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= BUSCA;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic; an all-zero IR decodes as an unknown opcode and halts
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      BUSCA: begin
        estado_d = DECODIFICA;
      end
      DECODIFICA: begin
        if (is_r || is_opimm) begin
          estado_d = EXECUCAO;
        end else if (is_lw || is_sw) begin
          estado_d = ENDERECO;
        end else if (beq_ok) begin
          estado_d = DESVIO;
        end else begin
          estado_d = PARADA;
        end
      end
      EXECUCAO: begin
        estado_d = PROXIMO;
      end
      ENDERECO: begin
        estado_d = MEMORIA;
      end
      MEMORIA: begin
        if (is_lw) begin
          estado_d = ESCRITA_MEM;
        end else if (is_sw) begin
          estado_d = PROXIMO;
        end else begin
          estado_d = PARADA;
        end
      end
      ESCRITA_MEM: begin
        estado_d = PROXIMO;
      end
      DESVIO: begin
        estado_d = PROXIMO;
      end
      PROXIMO: begin
        estado_d = BUSCA;
      end
      PARADA: begin
        estado_d = PARADA;
      end
      default: begin
        estado_d = PARADA;
      end
    endcase
  end

  // Architectural registers: IR loads on the fetch edge, while pc and
  // instret commit together on the PROXIMO edge. PARADA holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      case (estado_q)
        BUSCA: begin
          ir_q <= bus.instrucao;
        end
        PROXIMO: begin
          // The branch target is relative to the pc of the branch itself.
          pc_q      <= (branch_w && bus.zero) ? (pc_q + imm_w) : (pc_q + 32'd4);
          instret_q <= instret_q + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Immediate: sign-extended according to the instruction format
  always_comb begin
    imm_w = 32'd0;
    case (opcode)
      OP_IMM, OP_LW: imm_w = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_SW:         imm_w = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BEQ:        imm_w = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                              ir_q[11:8], 1'b0};
      default:       imm_w = 32'd0;
    endcase
  end

  // Datapath strobes, decoded from the current state and the IR opcode
  always_comb begin
    regiwrite_w = 1'b0;
    memtoreg_w  = 1'b0;
    memread_w   = 1'b0;
    memwrite_w  = 1'b0;
    alusrc_w    = 1'b0;
    branch_w    = 1'b0;
    aluop_w     = 2'b00;
    case (estado_q)
      EXECUCAO: begin
        regiwrite_w = is_r || is_opimm;
        alusrc_w    = uses_imm;
      end
      ENDERECO: begin
        alusrc_w = uses_imm;
      end
      MEMORIA: begin
        memread_w  = is_lw;
        memwrite_w = is_sw;
        alusrc_w   = uses_imm;
      end
      ESCRITA_MEM: begin
        regiwrite_w = is_lw;
        memtoreg_w  = 1'b1;
        alusrc_w    = uses_imm;
      end
      DESVIO, PROXIMO: begin
        branch_w = is_beq;
      end
      default: begin
      end
    endcase
    // ALU operation follows the opcode once IR holds a decoded instruction
    if ((estado_q != BUSCA) && (estado_q != PARADA)) begin
      case (opcode)
        OP_R:    aluop_w = 2'b10;
        OP_IMM:  aluop_w = 2'b11;
        OP_BEQ:  aluop_w = 2'b01;
        default: aluop_w = 2'b00;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.estado    = estado_q;
  assign bus.rs1       = ir_q[19:15];
  assign bus.rs2       = ir_q[24:20];
  assign bus.rd        = ir_q[11:7];
  assign bus.imm       = imm_w;
  assign bus.funct3    = ir_q[14:12];
  assign bus.funct7b5  = ir_q[30];
  assign bus.regiwrite = regiwrite_w;
  assign bus.memtoreg  = memtoreg_w;
  assign bus.memread   = memread_w;
  assign bus.memwrite  = memwrite_w;
  assign bus.alusrc    = alusrc_w;
  assign bus.branch    = branch_w;
  assign bus.aluop     = aluop_w;
  assign bus.parado    = (estado_q == PARADA);
  assign bus.instret   = instret_q;

endmodule
